// File: rtl/in_hand_shaking_buf.sv
// in_hand_shaking_buf
// Router input-port receiver. The link side uses an si/ri handshake and the
// input-FIFO side uses wr_en/full. A DEPTH-entry circular staging buffer sits
// between the two sides, so the port can accept and write one packet per clock.
// The packet written to the FIFO is always the head of the buffer. There is no
// bypass path, so the minimum latency is one cycle.
// Optional feature: define IN_HS_PARITY_EN to enable parity checking. When it
// is enabled, packets with odd parity are accepted but dropped. Each drop is
// reported on parity_err and counted in err_count.
module in_hand_shaking_buf #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              si,
  input  logic [DATA_W-1:0] in_packet,
  output logic              ri,
  input  logic              full,
  output logic              wr_en,
  output logic [DATA_W-1:0] output_packet,
  output logic [CNT_W-1:0]  occupancy
`ifdef IN_HS_PARITY_EN
  ,
  output logic              parity_err,
  output logic [7:0]        err_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              accept;
  logic              store;

  // Ready depends only on registered occupancy. A full buffer stays not-ready
  // even while it drains in the same cycle.
  assign ri     = reset_n && (occupancy != CNT_W'(DEPTH));
  assign accept = si && ri;

  // The write strobe follows full combinationally, so a FIFO stall takes effect at once.
  assign wr_en         = (occupancy != '0) && !full;
  assign output_packet = mem[rd_ptr];

`ifdef IN_HS_PARITY_EN
  logic pkt_ok;

  // Even parity over the whole word, including the parity bit itself.
  assign pkt_ok = ~^in_packet;
  assign store  = accept && pkt_ok;
`else
  assign store  = accept;
`endif

  // Occupancy counts stores minus drains. If a store and a drain happen in the
  // same cycle, the count does not change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else begin
      case ({store, wr_en})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Circular buffer storage. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (store) begin
        mem[wr_ptr] <= in_packet;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (wr_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef IN_HS_PARITY_EN
  // Drop reporting: a one-cycle pulse, plus a count that saturates at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      parity_err <= accept && !pkt_ok;
      if (accept && !pkt_ok && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_in_hand_shaking_buf.sv
// tb_in_hand_shaking_buf
// Drives two instances of the receiver: the default DEPTH=2 / 64-bit build,
// and a DEPTH=4 / 32-bit build. Expected packets go into queues on each
// accepted handshake and come out again on each write strobe.
module tb_in_hand_shaking_buf;

  logic        clk;
  logic        reset_n;

  logic        si2;
  logic        full2;
  logic [63:0] pkt2;
  logic        ri2;
  logic        wr2;
  logic [63:0] out2;
  logic [1:0]  occ2;

  logic        si4;
  logic        full4;
  logic [31:0] pkt4;
  logic        ri4;
  logic        wr4;
  logic [31:0] out4;
  logic [2:0]  occ4;

`ifdef IN_HS_PARITY_EN
  logic        pe2;
  logic [7:0]  ec2;
  logic        pe4;
  logic [7:0]  ec4;
`endif

  int checks = 0;
  int passes = 0;

  logic [63:0] sb2[$];
  logic [31:0] sb4[$];

  typedef struct {
    logic        si;
    logic        full;
    logic [63:0] pkt;
    logic        exp_ri;
    logic        exp_wr;
    logic [1:0]  exp_occ;
    logic        chk_out;
    logic [63:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  in_hand_shaking_buf #(.DATA_W(64), .DEPTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .si(si2), .in_packet(pkt2), .ri(ri2),
    .full(full2), .wr_en(wr2), .output_packet(out2), .occupancy(occ2)
`ifdef IN_HS_PARITY_EN
    , .parity_err(pe2), .err_count(ec2)
`endif
  );

  in_hand_shaking_buf #(.DATA_W(32), .DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .si(si4), .in_packet(pkt4), .ri(ri4),
    .full(full4), .wr_en(wr4), .output_packet(out4), .occupancy(occ4)
`ifdef IN_HS_PARITY_EN
    , .parity_err(pe4), .err_count(ec4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus2(input logic s, input logic [63:0] p, input logic f);
    @(negedge clk);
    si2 = s; pkt2 = p; full2 = f;
    #1;
    if (wr2) begin
      if (sb2.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb2_unexpected_write: got %h expected no write", out2);
      end else begin
        checkOutput("sb2_order", out2, sb2.pop_front());
      end
    end
    if (si2 && ri2) begin
`ifdef IN_HS_PARITY_EN
      if (^pkt2 == 1'b0) sb2.push_back(pkt2);
`else
      sb2.push_back(pkt2);
`endif
    end
  endtask

  task automatic applyStimulus4(input logic s, input logic [31:0] p, input logic f,
                                output logic acc, output logic wrote);
    @(negedge clk);
    si4 = s; pkt4 = p; full4 = f;
    #1;
    acc   = si4 && ri4;
    wrote = wr4;
    if (wr4) begin
      if (sb4.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb4_unexpected_write: got %h expected no write", out4);
      end else begin
        checkOutput("sb4_order", {32'd0, out4}, {32'd0, sb4.pop_front()});
      end
    end
    if (acc) sb4.push_back(pkt4);
  endtask

  function automatic logic [31:0] mk4(input int i);
    logic [30:0] b;
    b = 31'h40DE_0000 + 31'(i);
    return {^b, b};
  endfunction

  initial begin
    logic acc;
    logic wrote;
    int   sent;
    int   written;

    reset_n = 1'b0;
    si2 = 1'b0; full2 = 1'b0; pkt2 = '0;
    si4 = 1'b0; full4 = 1'b0; pkt4 = '0;

    // Reset state of both instances.
    #3;
    checkOutput("rst_ri2", ri2, 0);
    checkOutput("rst_wr2", wr2, 0);
    checkOutput("rst_occ2", occ2, 0);
    checkOutput("rst_out2", out2, 0);
    checkOutput("rst_ri4", ri4, 0);
    checkOutput("rst_occ4", occ4, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // si, full, pkt, exp_ri, exp_wr, exp_occ, chk_out, exp_out
    vecs.push_back('{1, 0, 64'h11, 1, 0, 0, 0, 64'h0});
    vecs.push_back('{1, 0, 64'h22, 1, 1, 1, 1, 64'h11});
    vecs.push_back('{1, 0, 64'h33, 1, 1, 1, 1, 64'h22});
    vecs.push_back('{1, 0, 64'h44, 1, 1, 1, 1, 64'h33});
    vecs.push_back('{0, 0, 64'h0,  1, 1, 1, 1, 64'h44});
    vecs.push_back('{0, 0, 64'h0,  1, 0, 0, 0, 64'h0});
    vecs.push_back('{1, 1, 64'hA,  1, 0, 0, 0, 64'h0});
    vecs.push_back('{1, 1, 64'h8000_0000_0000_000B, 1, 0, 1, 1, 64'hA});
    vecs.push_back('{1, 1, 64'hC,  0, 0, 2, 1, 64'hA});
    vecs.push_back('{1, 0, 64'hC,  0, 1, 2, 1, 64'hA});
    vecs.push_back('{1, 0, 64'hC,  1, 1, 1, 1, 64'h8000_0000_0000_000B});
    vecs.push_back('{0, 0, 64'h0,  1, 1, 1, 1, 64'hC});
    vecs.push_back('{0, 0, 64'h0,  1, 0, 0, 0, 64'h0});
    vecs.push_back('{1, 1, 64'h50, 1, 0, 0, 0, 64'h0});
    vecs.push_back('{1, 0, 64'h55, 1, 1, 1, 1, 64'h50});
    vecs.push_back('{0, 1, 64'h0,  1, 0, 1, 1, 64'h55});
    vecs.push_back('{0, 0, 64'h0,  1, 1, 1, 1, 64'h55});
    vecs.push_back('{1, 1, 64'h66, 1, 0, 0, 0, 64'h0});
    vecs.push_back('{1, 1, 64'h77, 1, 0, 1, 1, 64'h66});
    vecs.push_back('{0, 1, 64'h0,  0, 0, 2, 1, 64'h66});

    foreach (vecs[i]) begin
      applyStimulus2(vecs[i].si, vecs[i].pkt, vecs[i].full);
      checkOutput($sformatf("vec%0d_ri", i), ri2, vecs[i].exp_ri);
      checkOutput($sformatf("vec%0d_wr", i), wr2, vecs[i].exp_wr);
      checkOutput($sformatf("vec%0d_occ", i), occ2, vecs[i].exp_occ);
      if (vecs[i].chk_out) checkOutput($sformatf("vec%0d_out", i), out2, vecs[i].exp_out);
    end

    // Reset asserted mid-cycle while full: buffered packets vanish immediately.
    @(negedge clk);
    full2 = 1'b0; si2 = 1'b1; pkt2 = 64'h88;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t4_ri", ri2, 0);
    checkOutput("t4_wr", wr2, 0);
    checkOutput("t4_occ", occ2, 0);
    checkOutput("t4_out", out2, 0);
    sb2.delete();
    @(negedge clk);
    si2 = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus2(0, 64'h0, 0);
      checkOutput("t4_no_stale_wr", wr2, 0);
      checkOutput("t4_ri_back", ri2, 1);
    end

`ifdef IN_HS_PARITY_EN
    applyStimulus2(1, 64'h8000_0000_0000_0000, 0);
    checkOutput("t5_ri", ri2, 1);
    applyStimulus2(1, 64'h3, 0);
    checkOutput("t5_perr_pulse", pe2, 1);
    checkOutput("t5_occ_drop", occ2, 0);
    applyStimulus2(0, 64'h0, 0);
    checkOutput("t5_perr_clear", pe2, 0);
    checkOutput("t5_wr_good", wr2, 1);
    checkOutput("t5_errcnt", ec2, 1);
    applyStimulus2(0, 64'h0, 0);
    checkOutput("t5_wr_done", wr2, 0);
`endif

    // DEPTH=4: fill while stalled, then stream with a randomly toggling full.
    sent = 0;
    written = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus4(1, mk4(sent), 1, acc, wrote);
      if (c == 4) begin
        checkOutput("t6_ri_full", ri4, 0);
        checkOutput("t6_occ_full", occ4, 4);
      end
      if (acc) sent++;
    end
    checkOutput("t6_accepted", sent, 4);
    for (int c = 0; c < 300 && written < 10; c++) begin
      applyStimulus4(sent < 10, mk4(sent), ($urandom_range(0, 2) == 0), acc, wrote);
      if (acc) sent++;
      if (wrote) written++;
    end
    checkOutput("t6_written", written, 10);
    checkOutput("t6_sb_empty", sb4.size(), 0);
    applyStimulus4(0, 32'h0, 0, acc, wrote);
    checkOutput("t6_occ_end", occ4, 0);
    checkOutput("t6_wr_end", wr4, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
